dram_stream_loader: RTL and testbench

- Upstream feeder for the data RAM in the image-downsampling processor.
- Accepts a byte stream of image pixels over a valid/ready handshake. The stream starts with a 2-byte length header, big-endian.
- Writes each pixel byte into consecutive data-RAM addresses from BASE_ADDR.
- Reports completion or a length error to the controller so the processor can start downsampling.

---
 rtl/dram_stream_loader_if.sv | 21 ++
 rtl/dram_stream_loader.sv | 124 ++++++++++++
 tb/tb_dram_stream_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dram_stream_loader_if.sv
// rtl/dram_stream_loader_if.sv - pixel byte stream and data-RAM write port bundle
interface dram_stream_loader_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_write;

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_addr, mem_din, mem_write
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_addr, mem_din, mem_write
    );
endinterface

// File: rtl/dram_stream_loader.sv
// rtl/dram_stream_loader.sv - length-prefixed byte stream to data-RAM loader
module dram_stream_loader #(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_LEN   = 16384
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    dram_stream_loader_if.slave bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [15:0]         byte_count
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR_HI = 3'd1;
    localparam logic [2:0] S_HDR_LO = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              wr_q, wr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              ready;
    logic              accept;
    logic [15:0]       hdr_len;
    logic [15:0]       count_inc;

    assign ready     = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) || (state_q == S_LOAD);
    assign accept    = bus.s_valid && ready;
    assign hdr_len   = {len_q[15:8], bus.s_data};
    assign count_inc = count_q + 16'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        addr_d  = addr_q;
        din_d   = din_q;
        wr_d    = 1'b0;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // done lags DONE entry by one edge so the final RAM write has landed
                if (state_q == S_DONE) done_d = 1'b1;
                if (start) begin
                    state_d = S_HDR_HI;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    count_d = 16'd0;
                end
            end
            S_HDR_HI: begin
                if (accept) begin
                    len_d   = {bus.s_data, len_q[7:0]};
                    state_d = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (accept) begin
                    len_d = hdr_len;
                    if ({16'd0, hdr_len} > MAX_LEN) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (hdr_len == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    addr_d  = BASE_ADDR + ADDR_W'(count_q);
                    din_d   = bus.s_data;
                    wr_d    = 1'b1;
                    count_d = count_inc;
                    if (count_inc == len_q) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= 16'd0;
            count_q <= 16'd0;
            addr_q  <= BASE_ADDR;
            din_q   <= 8'd0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.s_ready   = ready;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_din   = din_q;
    assign bus.mem_write = wr_q;
    assign busy          = ready;
    assign done          = done_q;
    assign err           = err_q;
    assign byte_count    = count_q;
endmodule

// File: tb/tb_dram_stream_loader.sv
// tb/tb_dram_stream_loader.sv - self-checking bench for dram_stream_loader
module tb_dram_stream_loader;
    localparam int MAX_LEN = 16384;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       s_valid;
    logic [7:0] s_data;

    always #5 clk = ~clk;

    dram_stream_loader_if #(.ADDR_W(16)) bus_a ();
    dram_stream_loader_if #(.ADDR_W(16)) bus_b ();

    assign bus_a.s_valid = s_valid;
    assign bus_a.s_data  = s_data;
    assign bus_b.s_valid = s_valid;
    assign bus_b.s_data  = s_data;

    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [15:0] cnt_a, cnt_b;

    dram_stream_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000), .MAX_LEN(MAX_LEN)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_a),
        .busy(busy_a), .done(done_a), .err(err_a), .byte_count(cnt_a)
    );

    dram_stream_loader #(.ADDR_W(16), .BASE_ADDR(16'hFFFE), .MAX_LEN(MAX_LEN)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_b),
        .busy(busy_b), .done(done_b), .err(err_b), .byte_count(cnt_b)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic        acc_prev = 1'b0;
    logic [23:0] wr_a[$];
    logic [23:0] wr_b[$];
    logic [7:0]  pl[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // A RAM write must always be the echo of an accept one edge earlier
    always @(negedge clk) begin
        if (bus_a.mem_write === 1'b1) begin
            wr_a.push_back({bus_a.mem_addr, bus_a.mem_din});
            chk("wr_a_follows_accept", 32'(acc_prev), 32'd1);
        end
        if (bus_b.mem_write === 1'b1) begin
            wr_b.push_back({bus_b.mem_addr, bus_b.mem_din});
            chk("wr_b_follows_accept", 32'(acc_prev), 32'd1);
        end
        acc_prev = s_valid && bus_a.s_ready && rst_n;
    end

    task automatic pulse_start();
        wr_a.delete();
        wr_b.delete();
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        @(posedge clk); #1;
        start   = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int mode);
        int gap;
        int waited;
        gap = (mode == 1) ? 1 : ((mode == 2) ? int'($urandom_range(0, 2)) : 0);
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            start   = (mode == 2) && ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        waited  = 0;
        while (bus_a.s_ready !== 1'b1 && waited < 64) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 64) chk("s_ready_timeout", 32'(waited), 32'd0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic run_load(input logic [15:0] len, input int mode);
        int nexp;
        int na;
        int nb;
        pulse_start();
        send_byte(len[15:8], mode);
        send_byte(len[7:0], mode);
        if (int'(len) > MAX_LEN) begin
            @(negedge clk);
            chk("err_on_entry", 32'(err_a), 32'd1);
            chk("s_ready_in_err", 32'(bus_a.s_ready), 32'd0);
            @(negedge clk);
            chk("err_a_held", 32'(err_a), 32'd1);
            chk("err_b_held", 32'(err_b), 32'd1);
            chk("done_in_err", 32'(done_a), 32'd0);
            nexp = 0;
        end else begin
            for (int i = 0; i < int'(len); i++) send_byte(pl[i], mode);
            @(negedge clk);
            chk("done_not_early", 32'(done_a), 32'd0);
            @(negedge clk);
            chk("done_a", 32'(done_a), 32'd1);
            chk("done_b", 32'(done_b), 32'd1);
            chk("err_clear", 32'(err_a), 32'd0);
            nexp = int'(len);
        end
        chk("byte_count", 32'(cnt_a), 32'(nexp));
        chk("busy_idle", 32'(busy_a), 32'd0);
        chk("s_ready_idle", 32'(bus_a.s_ready), 32'd0);
        chk("write_count_a", 32'(wr_a.size()), 32'(nexp));
        chk("write_count_b", 32'(wr_b.size()), 32'(nexp));
        na = (wr_a.size() < nexp) ? wr_a.size() : nexp;
        nb = (wr_b.size() < nexp) ? wr_b.size() : nexp;
        for (int i = 0; i < na; i++)
            chk("write_a", 32'(wr_a[i]), 32'({16'(i), pl[i]}));
        for (int i = 0; i < nb; i++)
            chk("write_b", 32'(wr_b[i]), 32'({16'((32'hFFFE + i) % 65536), pl[i]}));
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_s_ready", 32'(bus_a.s_ready), 32'd0);
        chk("rst_mem_write", 32'(bus_a.mem_write), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_addr_a", 32'(bus_a.mem_addr), 32'h0000);
        chk("rst_addr_b", 32'(bus_b.mem_addr), 32'hFFFE);
        chk("rst_din", 32'(bus_a.mem_din), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        pl = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(16'd4, 0);
        run_load(16'd4, 1);
        run_load(16'd0, 0);
        run_load(16'h4001, 0);
        pl = {8'h55};
        run_load(16'd1, 0);

        pl = {8'h11, 8'h22, 8'h33, 8'h44};
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_byte(pl[0], 0);
        send_byte(pl[1], 0);
        s_valid = 1'b1;
        s_data  = pl[2];
        rst_n   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_mem_write", 32'(bus_a.mem_write), 32'd0);
        chk("mid_rst_count", 32'(cnt_a), 32'd0);
        chk("mid_rst_s_ready", 32'(bus_a.s_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_writes", 32'(wr_a.size()), 32'd2);
        if (wr_a.size() >= 2) chk("mid_rst_last_write", 32'(wr_a[1]), 32'h000122);

        for (int t = 0; t < 7; t++) begin
            int len;
            len = (t == 0) ? 5 : int'($urandom_range(1, 40));
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            run_load(16'(len), 2);
        end

        pl.delete();
        for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'($urandom));
        run_load(16'(MAX_LEN), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
